axi4stream_output_serializer: RTL and testbench

//  Next-generation wide-buffer -> AXI4-Stream master serializer for the video upscaler output path.

---
 rtl/axi4stream_output_serializer_if.sv | 34 +++
 rtl/axi4stream_output_serializer.sv | 67 ++++++
 tb/tb_axi4stream_output_serializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4stream_output_serializer_if.sv
// axi4stream_output_serializer_if: frame input handshake plus AXI4-Stream output bundle.
// tkeep is present only when AXIS_SER_TKEEP_EN is defined.
interface axi4stream_output_serializer_if #(
  parameter int AXI_WIDTH    = 8,
  parameter int BUFFER_WIDTH = 80
);
  logic [BUFFER_WIDTH-1:0] input_buffer;
  logic                    input_buffer_valid;
  logic                    input_buffer_ready;
  logic [AXI_WIDTH-1:0]    tdata;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;
`ifdef AXIS_SER_TKEEP_EN
  logic [AXI_WIDTH/8-1:0]  tkeep;
  modport master (
    input  input_buffer, input_buffer_valid, tready,
    output input_buffer_ready, tdata, tvalid, tlast, tkeep
  );
  modport slave (
    output input_buffer, input_buffer_valid, tready,
    input  input_buffer_ready, tdata, tvalid, tlast, tkeep
  );
`else
  modport master (
    input  input_buffer, input_buffer_valid, tready,
    output input_buffer_ready, tdata, tvalid, tlast
  );
  modport slave (
    output input_buffer, input_buffer_valid, tready,
    input  input_buffer_ready, tdata, tvalid, tlast
  );
`endif
endinterface

// File: rtl/axi4stream_output_serializer.sv
// axi4stream_output_serializer: wide frame -> LSB-first AXI4-Stream beats with one-deep holding register.
// Optional tkeep output enabled by defining AXIS_SER_TKEEP_EN.
module axi4stream_output_serializer #(
  parameter int AXI_WIDTH       = 8,
  parameter int BUFFER_WIDTH    = 80,
  parameter int PACKETS_PER_TXN = 5
) (
  input  logic                            aclk,
  input  logic                            areset,
  axi4stream_output_serializer_if.master  s,
  output logic                            busy
);
  localparam int NUM_PACKETS = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
  localparam int SW  = NUM_PACKETS * AXI_WIDTH;
  localparam int BCW = NUM_PACKETS > 1 ? $clog2(NUM_PACKETS) : 1;
  localparam int TCW = PACKETS_PER_TXN > 1 ? $clog2(PACKETS_PER_TXN) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                  state, state_n;
  logic [SW-1:0]           sh;
  logic [BUFFER_WIDTH-1:0] hold;
  logic                    hold_full;
  logic [BCW-1:0]          beat_cnt;
  logic [TCW-1:0]          txn_cnt;
  logic                    hs, last_beat, fin, take, load;
  // A load happens whenever the shifter is (or is about to become) free and a frame is available.
  always_comb begin
    last_beat = beat_cnt == BCW'(NUM_PACKETS - 1);
    hs        = s.tvalid && s.tready;
    fin       = hs && last_beat;
    take      = s.input_buffer_valid && s.input_buffer_ready;
    load      = (!s.tvalid || fin) && (hold_full || take);
    state_n   = load ? SEND : fin ? IDLE : state;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      beat_cnt  <= '0;
      txn_cnt   <= '0;
    end else begin
      state <= state_n;
      if (load) sh <= hold_full ? SW'(hold) : SW'(s.input_buffer);
      else if (hs) sh <= sh >> AXI_WIDTH;
      if (take && !load) begin
        hold      <= s.input_buffer;
        hold_full <= 1'b1;
      end else if (load && hold_full) hold_full <= 1'b0;
      if (hs) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        txn_cnt  <= s.tlast ? '0 : txn_cnt + 1'b1;
      end
    end
  end
  assign s.tvalid             = state == SEND;
  assign s.tdata              = sh[AXI_WIDTH-1:0];
  assign s.tlast              = s.tvalid && (last_beat || txn_cnt == TCW'(PACKETS_PER_TXN - 1));
  assign s.input_buffer_ready = !hold_full;
  assign busy                 = s.tvalid || hold_full;
`ifdef AXIS_SER_TKEEP_EN
  localparam int KW         = AXI_WIDTH / 8;
  localparam int LAST_BYTES = (BUFFER_WIDTH - (NUM_PACKETS - 1) * AXI_WIDTH + 7) / 8;
  localparam logic [KW-1:0] LAST_KEEP = {KW{1'b1}} >> (KW - LAST_BYTES);
  assign s.tkeep = last_beat ? LAST_KEEP : {KW{1'b1}};
`endif
endmodule

// File: tb/tb_axi4stream_output_serializer.sv
// tb_axi4stream_output_serializer: scoreboard bench for two serializer configurations (80-bit/5 and 35-bit/10).
module tb_axi4stream_output_serializer;
  typedef struct packed {logic [7:0] d; logic l; logic k;} beat_t;
  logic aclk, areset, busy0, busy1;
  int   total = 0, bad = 0, mode = 0, cyc = 0;
  beat_t q0[$], q1[$];
  logic  stall[2], pl[2];
  logic [7:0] pd[2];
  axi4stream_output_serializer_if #(.AXI_WIDTH(8), .BUFFER_WIDTH(80)) b0();
  axi4stream_output_serializer_if #(.AXI_WIDTH(8), .BUFFER_WIDTH(35)) b1();
  axi4stream_output_serializer #(.AXI_WIDTH(8), .BUFFER_WIDTH(80), .PACKETS_PER_TXN(5))
    u0 (.aclk(aclk), .areset(areset), .s(b0), .busy(busy0));
  axi4stream_output_serializer #(.AXI_WIDTH(8), .BUFFER_WIDTH(35), .PACKETS_PER_TXN(10))
    u1 (.aclk(aclk), .areset(areset), .s(b1), .busy(busy1));
  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: beat i carries bits [8i+7:8i]; tlast every PPT beats and on the frame's last beat.
  task automatic push_model(input int k, input logic [79:0] f);
    int bw, ppt, np;
    logic [79:0] t;
    beat_t e;
    bw  = k ? 35 : 80;
    ppt = k ? 10 : 5;
    np  = (bw + 7) / 8;
    if (k != 0) f[79:35] = '0;
    for (int i = 0; i < np; i++) begin
      t   = f >> (8 * i);
      e.d = t[7:0];
      e.l = (i % ppt == ppt - 1) || (i == np - 1);
      e.k = 1'b1;
      if (k != 0) q1.push_back(e); else q0.push_back(e);
    end
  endtask
  task automatic push_const(input int k, input logic [7:0] d, input logic l);
    beat_t e;
    e.d = d; e.l = l; e.k = 1'b1;
    if (k != 0) q1.push_back(e); else q0.push_back(e);
  endtask
  task automatic send(input int k, input logic [79:0] f, input bit model);
    int n = 0;
    if (k != 0) begin b1.input_buffer = f[34:0]; b1.input_buffer_valid = 1'b1; end
    else begin b0.input_buffer = f; b0.input_buffer_valid = 1'b1; end
    while (!(k != 0 ? b1.input_buffer_ready : b0.input_buffer_ready) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL accept%0d: input_buffer_ready stayed 0, expected 1", k);
    end else if (model) push_model(k, f);
    @(negedge aclk);
    if (k != 0) b1.input_buffer_valid = 1'b0; else b0.input_buffer_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || b0.tvalid || b1.tvalid) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 1);
  endtask
  task automatic check_beat(input int k, input logic tv, input logic tr, input logic [7:0] td,
                            input logic tl, input logic tk);
    beat_t e;
    if (stall[k]) begin
      total++;
      if (!tv || td !== pd[k] || tl !== pl[k]) begin
        bad++;
        $display("FAIL stable%0d: tvalid=%0b tdata=%h tlast=%0b, held values tvalid=1 tdata=%h tlast=%0b",
                 k, tv, td, tl, pd[k], pl[k]);
      end
    end
    stall[k] = tv && !tr;
    pd[k] = td;
    pl[k] = tl;
    if (tv && tr) begin
      total++;
      if ((k != 0 ? q1.size() : q0.size()) == 0) begin
        bad++;
        $display("FAIL beat%0d: unexpected beat tdata=%h tlast=%0b, expected none", k, td, tl);
      end else begin
        if (k != 0) e = q1.pop_front(); else e = q0.pop_front();
        if (td !== e.d || tl !== e.l || tk !== e.k) begin
          bad++;
          $display("FAIL beat%0d: got tdata=%h tlast=%0b tkeep=%0b expected tdata=%h tlast=%0b tkeep=%0b",
                   k, td, tl, tk, e.d, e.l, e.k);
        end
      end
    end
  endtask
  initial begin
    logic tk0, tk1;
    stall = '{1'b0, 1'b0};
    forever begin
      @(negedge aclk);
`ifdef AXIS_SER_TKEEP_EN
      tk0 = b0.tkeep[0];
      tk1 = b1.tkeep[0];
`else
      tk0 = 1'b1;
      tk1 = 1'b1;
`endif
      if (areset) stall = '{1'b0, 1'b0};
      else begin
        check_beat(0, b0.tvalid, b0.tready, b0.tdata, b0.tlast, tk0);
        check_beat(1, b1.tvalid, b1.tready, b1.tdata, b1.tlast, tk1);
      end
    end
  end
  initial begin
    b0.tready = 1'b1;
    b1.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      b0.tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
      b1.tready = mode == 2 ? ($urandom_range(0, 2) != 0) : b0.tready;
    end
  end
  initial begin
    logic [79:0] f2;
    logic [95:0] w;
    logic [7:0]  exp2 [10];
    logic [7:0]  exp5 [5];
    f2   = {8'hFF, 32'hCAFEB0BA, 8'hFF, 32'hDEADBEEF};
    exp2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF, 8'hBA, 8'hB0, 8'hFE, 8'hCA, 8'hFF};
    exp5 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h07};
    areset = 1'b1;
    b0.input_buffer = '0; b0.input_buffer_valid = 1'b0;
    b1.input_buffer = '0; b1.input_buffer_valid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 32'(b0.tvalid), 0);
    chk("rst_tlast", 32'(b0.tlast), 0);
    chk("rst_tdata", 32'(b0.tdata), 0);
    chk("rst_ready", 32'(b0.input_buffer_ready), 1);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_tvalid_b1", 32'(b1.tvalid), 0);
    chk("rst_ready_b1", 32'(b1.input_buffer_ready), 1);
    areset = 1'b0;
    @(negedge aclk);
    // Basic frame with fixed expected bytes, then the 35-bit partial-beat frame
    chk("idle_tvalid", 32'(b0.tvalid), 0);
    for (int i = 0; i < 10; i++) push_const(0, exp2[i], i == 4 || i == 9);
    send(0, f2, 0);
    chk("latency_tvalid", 32'(b0.tvalid), 1);
    drain();
    for (int i = 0; i < 5; i++) push_const(1, exp5[i], i == 4);
    send(1, 80'h7_DEADBEEF, 0);
    drain();
    // Backpressure pattern 1,0,0
    mode = 1;
    @(negedge aclk);
    send(0, f2, 1);
    drain();
    // Back-to-back frames: second is held, output is gapless
    mode = 0;
    @(negedge aclk);
    @(negedge aclk);
    send(0, f2, 1);
    send(0, ~f2, 1);
    chk("b2b_ready_low", 32'(b0.input_buffer_ready), 0);
    chk("b2b_busy", 32'(busy0), 1);
    for (int i = 0; i < 19; i++) begin
      chk("b2b_gapless", 32'(b0.tvalid), 1);
      @(negedge aclk);
    end
    chk("b2b_end_tvalid", 32'(b0.tvalid), 0);
    chk("b2b_queue_empty", 32'(q0.size()), 0);
    drain();
    // Reset mid-frame with a held frame
    send(0, f2, 1);
    send(0, ~f2, 1);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge aclk);
    @(negedge aclk);
    chk("midrst_tvalid", 32'(b0.tvalid), 0);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_ready", 32'(b0.input_buffer_ready), 1);
    areset = 1'b0;
    @(negedge aclk);
    send(0, ~f2 ^ 80'h1234_5678_9ABC_DEF0_1357, 1);
    drain();
    // Randomised frames, gaps and backpressure on both configurations
    mode = 2;
    for (int i = 0; i < 60; i++) begin
      w = {$urandom(), $urandom(), $urandom()};
      send($urandom_range(0, 1), w[79:0], 1);
      repeat ($urandom_range(0, 3)) @(negedge aclk);
    end
    drain();
    chk("final_busy0", 32'(busy0), 0);
    chk("final_busy1", 32'(busy1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
